// File: rtl/trap_pkg.sv
// Shared constants and types for the trap unit: exception bit positions,
// mcause codes, CSR select encodings and the trap sequencer states.
package trap_pkg;

    localparam int unsigned EXC_W      = 7;

    localparam int unsigned EXC_LD_MIS = 0;
    localparam int unsigned EXC_LD_ACC = 1;
    localparam int unsigned EXC_ST_MIS = 2;
    localparam int unsigned EXC_ST_ACC = 3;
    localparam int unsigned EXC_LD_PF  = 4;
    localparam int unsigned EXC_ST_PF  = 5;
    localparam int unsigned EXC_BRK    = 6;

    localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACC = 4'd7;
    localparam logic [3:0] CAUSE_LD_PF  = 4'd13;
    localparam logic [3:0] CAUSE_ST_PF  = 4'd15;
    localparam logic [3:0] CAUSE_BRK    = 4'd3;

    localparam logic [1:0] CSR_MTVEC  = 2'd0;
    localparam logic [1:0] CSR_MEPC   = 2'd1;
    localparam logic [1:0] CSR_MCAUSE = 2'd2;
    localparam logic [1:0] CSR_MTVAL  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        TFLUSH,
        TREDIR,
        MFLUSH,
        MREDIR
    } trap_state_t;

endpackage

// File: rtl/except_prio.sv
// Exception vector prioritiser: picks the single architectural cause and
// whether mtval should carry the PC (breakpoint) instead of the data address.
module except_prio
    import trap_pkg::*;
(
    input  logic [EXC_W-1:0] exc,
    output logic             hit,
    output logic [3:0]       cause,
    output logic             use_pc
);

    // Fixed-priority select, highest-priority exception first.
    always_comb begin
        hit    = |exc;
        cause  = '0;
        use_pc = 1'b0;
        if (exc[EXC_BRK]) begin
            cause  = CAUSE_BRK;
            use_pc = 1'b1;
        end else if (exc[EXC_ST_PF]) begin
            cause = CAUSE_ST_PF;
        end else if (exc[EXC_LD_PF]) begin
            cause = CAUSE_LD_PF;
        end else if (exc[EXC_ST_MIS]) begin
            cause = CAUSE_ST_MIS;
        end else if (exc[EXC_LD_MIS]) begin
            cause = CAUSE_LD_MIS;
        end else if (exc[EXC_ST_ACC]) begin
            cause = CAUSE_ST_ACC;
        end else if (exc[EXC_LD_ACC]) begin
            cause = CAUSE_LD_ACC;
        end
    end

endmodule

// File: rtl/trap_unit.sv
// Trap unit: turns the EX exception vector into an architectural trap,
// holds mtvec/mepc/mcause/mtval, and sequences flush + fetch redirect for
// both trap entry and mret.
module trap_unit
    import trap_pkg::*;
#(
    parameter int unsigned    N         = 64,
    parameter logic [N-1:0]   MTVEC_RST = '0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [EXC_W-1:0] exceptSignal,
    input  logic             valid_E,
    input  logic [N-1:0]     pc_E,
    input  logic [N-1:0]     addr_E,
    input  logic             mret_E,
    input  logic             csr_we,
    input  logic [1:0]       csr_sel,
    input  logic [N-1:0]     csr_wdata,
    output logic [N-1:0]     csr_rdata,
    output logic             flush,
    output logic             redirect,
    output logic [N-1:0]     redirect_pc,
    output logic             trap_busy
);

    logic        exc_hit;
    logic [3:0]  exc_cause;
    logic        exc_use_pc;

    trap_state_t state, state_nx;

    logic [N-1:0] mtvec, mepc, mcause, mtval;
    logic [N-1:0] pc_hold;
    logic         trap_take, mret_take;

    except_prio u_prio (
        .exc    (exceptSignal),
        .hit    (exc_hit),
        .cause  (exc_cause),
        .use_pc (exc_use_pc)
    );

    // Trap/mret acceptance; only in IDLE with a real EX instruction, exception beats mret.
    always_comb begin
        trap_take = ~reset & (state == IDLE) & valid_E & exc_hit;
        mret_take = ~reset & (state == IDLE) & valid_E & mret_E & ~exc_hit;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and flush/redirect outputs; redirect_pc holds its last value when idle.
    always_comb begin
        state_nx    = state;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = pc_hold;
        case (state)
            IDLE: begin
                // flush in the trap cycle itself squashes the faulting store
                flush = trap_take;
                if (trap_take)      state_nx = TFLUSH;
                else if (mret_take) state_nx = MFLUSH;
            end
            TFLUSH: begin
                flush    = 1'b1;
                state_nx = TREDIR;
            end
            TREDIR: begin
                // mtvec is read here so a write landing during TFLUSH is honoured
                redirect    = 1'b1;
                redirect_pc = {mtvec[N-1:2], 2'b00};
                state_nx    = IDLE;
            end
            MFLUSH: begin
                flush    = 1'b1;
                state_nx = MREDIR;
            end
            MREDIR: begin
                redirect    = 1'b1;
                redirect_pc = mepc;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        trap_busy = (state != IDLE);
    end

    // CSR file; a trap latch overrides a coincident software write to mepc/mcause/mtval.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec  <= MTVEC_RST;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else begin
            if (csr_we) begin
                case (csr_sel)
                    CSR_MTVEC:  mtvec  <= csr_wdata;
                    CSR_MEPC:   mepc   <= csr_wdata;
                    CSR_MCAUSE: mcause <= csr_wdata;
                    CSR_MTVAL:  mtval  <= csr_wdata;
                    default:    ;
                endcase
            end
            if (trap_take) begin
                mepc   <= pc_E;
                mcause <= {{(N-4){1'b0}}, exc_cause};
                mtval  <= exc_use_pc ? pc_E : addr_E;
            end
        end
    end

    // Remember the last redirect target so redirect_pc is stable between redirects.
    always_ff @(posedge clk) begin
        if (reset)         pc_hold <= '0;
        else if (redirect) pc_hold <= redirect_pc;
    end

    // Combinational CSR read port.
    always_comb begin
        csr_rdata = '0;
        case (csr_sel)
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MTVAL:  csr_rdata = mtval;
            default:    csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// Testbench for trap_unit: a directed table of cycle vectors followed by
// randomized traffic checked against an event-queue reference model.
module tb_trap_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  exceptSignal;
    logic        valid_E;
    logic [63:0] pc_E;
    logic [63:0] addr_E;
    logic        mret_E;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        flush;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        trap_busy;

    int tests = 0;
    int fails = 0;

    trap_unit #(.N(64), .MTVEC_RST(64'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .exceptSignal (exceptSignal),
        .valid_E      (valid_E),
        .pc_E         (pc_E),
        .addr_E       (addr_E),
        .mret_E       (mret_E),
        .csr_we       (csr_we),
        .csr_sel      (csr_sel),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .trap_busy    (trap_busy)
    );

    // Free-running clock, posedge at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [6:0]  exc;
        logic        vld;
        logic [63:0] pc;
        logic [63:0] addr;
        logic        mret;
        logic        we;
        logic [1:0]  sel;
        logic [63:0] wd;
        logic        chk;
        logic        ef;
        logic        er;
        logic [63:0] erpc;
        logic        eb;
        logic [63:0] erd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [6:0] exc, logic vld, logic [63:0] pc,
                                logic [63:0] addr, logic mret, logic we, logic [1:0] sel,
                                logic [63:0] wd, logic chk, logic ef, logic er,
                                logic [63:0] erpc, logic eb, logic [63:0] erd);
        vec_t v;
        v.rst = rst; v.exc = exc; v.vld = vld; v.pc = pc; v.addr = addr; v.mret = mret;
        v.we = we; v.sel = sel; v.wd = wd; v.chk = chk; v.ef = ef; v.er = er;
        v.erpc = erpc; v.eb = eb; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [6:0] exc, input logic vld,
                         input logic [63:0] pc, input logic [63:0] addr, input logic mret,
                         input logic we, input logic [1:0] sel, input logic [63:0] wd);
        reset = rst; exceptSignal = exc; valid_E = vld; pc_E = pc; addr_E = addr;
        mret_E = mret; csr_we = we; csr_sel = sel; csr_wdata = wd;
    endtask

    task automatic check_outs(input string tag, input logic ef, input logic er,
                              input logic [63:0] erpc, input logic eb, input logic [63:0] erd);
        check($sformatf("%s flush", tag), {63'b0, flush}, {63'b0, ef});
        check($sformatf("%s redirect", tag), {63'b0, redirect}, {63'b0, er});
        check($sformatf("%s redirect_pc", tag), redirect_pc, erpc);
        check($sformatf("%s trap_busy", tag), {63'b0, trap_busy}, {63'b0, eb});
        check($sformatf("%s csr_rdata", tag), csr_rdata, erd);
    endtask

    // Reference model: trap ordering and pending pipeline actions as a queue.
    typedef struct { bit f; bit r; bit m; } ev_t;
    ev_t         evq[$];
    logic [63:0] csr[4];
    logic [63:0] last_pc;
    int          order[7] = '{6, 5, 4, 2, 0, 3, 1};
    int          code[7]  = '{3, 15, 13, 6, 4, 7, 5};

    initial begin
        ev_t         ev;
        logic        ef, er, eb, idle;
        logic [63:0] erpc;
        logic        rst, vld, mret, we;
        logic [6:0]  exc;
        logic [63:0] pc, addr, wd;
        logic [1:0]  sel;
        int          k;

        drive(1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0);

        //        rst exc         vld pc       addr      mret we sel wd        chk ef er erpc      eb erd
        tbl.push_back(mk(1, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    0, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        // load misaligned
        tbl.push_back(mk(0, 7'b0000001, 1, 64'h100, 64'h1003, 0, 0, 0, 64'h0,    1, 1, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 1, 0, 64'h0,    1, 64'h100));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 0, 1, 64'h0,    1, 64'h4));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 0, 64'h0,    0, 64'h1003));
        // breakpoint beats misaligned bits; mtval = pc
        tbl.push_back(mk(0, 7'b1000101, 1, 64'h200, 64'h2000, 0, 0, 0, 64'h0,    1, 1, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 1, 0, 64'h0,    1, 64'h3));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 1, 64'h0,    1, 64'h200));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h0,    0, 64'h200));
        // store access fault beats load access fault
        tbl.push_back(mk(0, 7'b0001010, 1, 64'h300, 64'h3008, 0, 0, 0, 64'h0,    1, 1, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 1, 0, 64'h0,    1, 64'h7));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 1, 64'h0,    1, 64'h3008));
        // mtvec write, visible next cycle
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 1, 0, 64'h8003, 1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    1, 0, 0, 64'h0,    0, 64'h8003));
        // trap; exceptions during TFLUSH/TREDIR and with valid_E=0 are ignored
        tbl.push_back(mk(0, 7'b0000001, 1, 64'h100, 64'h1003, 0, 0, 0, 64'h0,    1, 1, 0, 64'h0,    0, 64'h8003));
        tbl.push_back(mk(0, 7'b0000010, 1, 64'h999, 64'h777,  0, 0, 2, 64'h0,    1, 1, 0, 64'h0,    1, 64'h4));
        tbl.push_back(mk(0, 7'b0100000, 1, 64'h998, 64'h776,  0, 0, 1, 64'h0,    1, 0, 1, 64'h8000, 1, 64'h100));
        tbl.push_back(mk(0, 7'b0000001, 0, 64'h997, 64'h775,  0, 0, 2, 64'h0,    1, 0, 0, 64'h8000, 0, 64'h4));
        // mret
        tbl.push_back(mk(0, 7'b0000000, 1, 64'h50,  64'h0,    1, 0, 3, 64'h0,    1, 0, 0, 64'h8000, 0, 64'h1003));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 1, 0, 64'h8000, 1, 64'h100));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 1, 64'h100,  1, 64'h100));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h100,  0, 64'h100));
        // mret + store misaligned together: trap path only
        tbl.push_back(mk(0, 7'b0000100, 1, 64'h400, 64'h4004, 1, 0, 0, 64'h0,    1, 1, 0, 64'h100,  0, 64'h8003));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 1, 0, 64'h100,  1, 64'h6));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 1, 64'h8000, 1, 64'h4004));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h8000, 0, 64'h400));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h8000, 0, 64'h400));
        // mtvec written during TFLUSH is used by TREDIR
        tbl.push_back(mk(0, 7'b1000000, 1, 64'h500, 64'h5,    0, 0, 0, 64'h0,    1, 1, 0, 64'h8000, 0, 64'h8003));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 1, 0, 64'h9000, 1, 1, 0, 64'h8000, 1, 64'h8003));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    1, 0, 1, 64'h9000, 1, 64'h9000));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 0, 64'h9000, 0, 64'h500));
        // csr write to mcause coincides with trap: trap wins
        tbl.push_back(mk(0, 7'b0010000, 1, 64'h600, 64'h6660, 0, 1, 2, 64'habc,  1, 1, 0, 64'h9000, 0, 64'h3));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 1, 0, 64'h9000, 1, 64'hd));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 1, 64'h9000, 1, 64'h600));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 0, 64'h9000, 0, 64'h6660));
        // reset during TFLUSH
        tbl.push_back(mk(0, 7'b0000001, 1, 64'h700, 64'h7000, 0, 0, 0, 64'h0,    1, 1, 0, 64'h9000, 0, 64'h9000));
        tbl.push_back(mk(1, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    1, 1, 0, 64'h9000, 1, 64'h9000));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 0, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 1, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 2, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));
        tbl.push_back(mk(0, 7'b0000000, 0, 64'h0,   64'h0,    0, 0, 3, 64'h0,    1, 0, 0, 64'h0,    0, 64'h0));

        // Directed table: inputs applied after posedge, outputs checked at negedge.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].exc, tbl[i].vld, tbl[i].pc, tbl[i].addr,
                  tbl[i].mret, tbl[i].we, tbl[i].sel, tbl[i].wd);
            @(negedge clk);
            if (tbl[i].chk)
                check_outs($sformatf("vec%0d", i), tbl[i].ef, tbl[i].er, tbl[i].erpc,
                           tbl[i].eb, tbl[i].erd);
            @(posedge clk);
            #1;
        end

        // Random phase: one reset cycle to align the model, then free traffic.
        drive(1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0);
        @(posedge clk);
        #1;
        evq.delete();
        for (int j = 0; j < 4; j++) csr[j] = '0;
        last_pc = '0;

        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) < 2);
            exc  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0;
            vld  = ($urandom_range(0, 3) != 0);
            pc   = {$urandom, $urandom};
            addr = {$urandom, $urandom};
            mret = ($urandom_range(0, 9) == 0);
            we   = ($urandom_range(0, 9) == 0);
            sel  = 2'($urandom);
            wd   = {$urandom, $urandom};
            drive(rst, exc, vld, pc, addr, mret, we, sel, wd);

            idle = (evq.size() == 0);
            if (idle) begin
                ef = !rst && vld && (exc != 0);
                er = 1'b0;
                eb = 1'b0;
                erpc = last_pc;
            end else begin
                ev = evq[0];
                ef = ev.f;
                er = ev.r;
                eb = 1'b1;
                erpc = !ev.r ? last_pc : (ev.m ? csr[1] : (csr[0] & ~64'h3));
            end

            @(negedge clk);
            check_outs($sformatf("rnd%0d", c), ef, er, erpc, eb, csr[sel]);

            if (rst) begin
                evq.delete();
                for (int j = 0; j < 4; j++) csr[j] = '0;
                last_pc = '0;
            end else begin
                if (!idle) begin
                    if (er) last_pc = erpc;
                    void'(evq.pop_front());
                end
                if (we) csr[sel] = wd;
                if (idle && vld && exc != 0) begin
                    k = 0;
                    while (!exc[order[k]]) k++;
                    csr[1] = pc;
                    csr[2] = 64'(code[k]);
                    csr[3] = (order[k] == 6) ? pc : addr;
                    evq.push_back('{f: 1'b1, r: 1'b0, m: 1'b0});
                    evq.push_back('{f: 1'b0, r: 1'b1, m: 1'b0});
                end else if (idle && vld && mret) begin
                    evq.push_back('{f: 1'b1, r: 1'b0, m: 1'b0});
                    evq.push_back('{f: 1'b0, r: 1'b1, m: 1'b1});
                end
            end

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
